// File: rtl/tinybf_rst_pkg.sv
// Shared definitions for the reset sequencing controller: FSM state
// encodings, reset-cause codes and a counter-width helper.
package tinybf_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10,
    ST_SW_HOLD = 2'b11
  } rst_state_e;

  localparam logic [1:0] RST_CAUSE_NONE = 2'b00;
  localparam logic [1:0] RST_CAUSE_PIN  = 2'b01;
  localparam logic [1:0] RST_CAUSE_SW   = 2'b10;

  // Width of a counter that must hold values 0..n-1 with one bit of headroom.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/reset_seq_ctrl_sync_chain.sv
// Reset synchroniser: asynchronous assertion, synchronous deassertion.
// A chain of STAGES flops is cleared by async_rst_i and shifts in ones
// once the pad reset is released; the last stage is the synchronised reset.
module rst_sync_chain #(
  parameter int STAGES = 3
) (
  input  logic clk_i,
  input  logic async_rst_i,
  output logic rst_synced
);

  // The chain must survive synthesis untouched and be placed as metastability flops.
  (* keep = "true", dont_touch = "true", async_reg = "true" *)
  logic [STAGES-1:0] sync_q;

  // Shift ones in after release; clear the whole chain the moment reset asserts.
  // NOTE: asynchronous active-low clear lives in the sensitivity list so the
  // chain empties without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) sync_q <= '0;
    else              sync_q <= {sync_q[STAGES-2:0], 1'b1};
  end

  assign rst_synced = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencing controller. Synchronises the pad reset, then releases
// NUM_DOMAINS active-low domain resets one at a time, RELEASE_GAP cycles
// apart. A software request accepted in RUN holds every domain for
// SW_RST_CYCLES cycles and replays the release sequence.
// Optional build macro RST_SEQ_CAUSE_EN: when defined, rst_cause_o reports
// the cause of the last reset; when undefined it is tied to 2'b00.
module reset_seq_ctrl
  import tinybf_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = 3,
  parameter int NUM_DOMAINS   = 3,
  parameter int RELEASE_GAP   = 4,
  parameter int SW_RST_CYCLES = 8
) (
  input  logic                   clk_i,
  input  logic                   async_rst_i,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_o,
  output logic                   all_released_o,
  output logic                   busy_o,
  output logic [1:0]             rst_cause_o
);

  localparam int GAP_W = cnt_width(RELEASE_GAP);
  localparam int SW_W  = cnt_width(SW_RST_CYCLES);

  localparam logic [GAP_W-1:0]       GAP_LAST = GAP_W'(RELEASE_GAP - 1);
  localparam logic [SW_W-1:0]        SW_LAST  = SW_W'(SW_RST_CYCLES - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE  = NUM_DOMAINS'(1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL  = '1;

  // Reject illegal parameter combinations at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_sync
    $error("reset_seq_ctrl: SYNC_STAGES must be in 2..8");
  end
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_domains
    $error("reset_seq_ctrl: NUM_DOMAINS must be in 1..8");
  end
  if (RELEASE_GAP < 1) begin : g_bad_gap
    $error("reset_seq_ctrl: RELEASE_GAP must be 1 or more");
  end
  if (SW_RST_CYCLES < 1) begin : g_bad_sw
    $error("reset_seq_ctrl: SW_RST_CYCLES must be 1 or more");
  end

  logic                   rst_synced;
  rst_state_e             state_q;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic [SW_W-1:0]        sw_cnt_q;
  logic [NUM_DOMAINS-1:0] domain_q;
  logic                   all_released_q;
  logic                   busy_q;

  logic [NUM_DOMAINS-1:0] domain_next;
  logic                   release_last;
  logic                   release_now;
  logic                   sw_accept;

  rst_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk_i),
    .async_rst_i(async_rst_i),
    .rst_synced (rst_synced)
  );

  // Domains release in bit order, so the released mask is a run of ones:
  // one more release shifts in another one from the bottom.
  assign domain_next  = (domain_q << 1) | DOM_ONE;
  assign release_last = (domain_next == DOM_ALL);
  assign sw_accept    = (state_q == ST_RUN) && sw_rst_req_i;
  assign release_now  = ((state_q == ST_HOLD)    && rst_synced)           ||
                        ((state_q == ST_RELEASE) && (gap_cnt_q == GAP_LAST)) ||
                        ((state_q == ST_SW_HOLD) && (sw_cnt_q  == SW_LAST));

  // Sequencing FSM with registered domain, released and busy outputs.
  // NOTE: every register here is assigned with <= so all state updates
  // take effect together at the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q        <= ST_HOLD;
      gap_cnt_q      <= '0;
      sw_cnt_q       <= '0;
      domain_q       <= '0;
      all_released_q <= 1'b0;
      busy_q         <= 1'b1;
    end else if (release_now) begin
      domain_q  <= domain_next;
      gap_cnt_q <= '0;
      if (release_last) begin
        state_q        <= ST_RUN;
        all_released_q <= 1'b1;
        busy_q         <= 1'b0;
      end else begin
        state_q <= ST_RELEASE;
      end
    end else begin
      case (state_q)
        ST_RELEASE: gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        ST_SW_HOLD: sw_cnt_q  <= sw_cnt_q + SW_W'(1);
        ST_RUN: begin
          if (sw_rst_req_i) begin
            state_q        <= ST_SW_HOLD;
            sw_cnt_q       <= '0;
            domain_q       <= '0;
            all_released_q <= 1'b0;
            busy_q         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign domain_rst_o   = domain_q;
  assign all_released_o = all_released_q;
  assign busy_o         = busy_q;

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause_q;

  // Remember what caused the most recent reset until the next reset event.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i)   cause_q <= RST_CAUSE_PIN;
    else if (sw_accept) cause_q <= RST_CAUSE_SW;
  end

  assign rst_cause_o = cause_q;
`else
  logic unused_sw_accept;
  assign unused_sw_accept = sw_accept;
  assign rst_cause_o      = RST_CAUSE_NONE;
`endif

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl. A default-parameter instance covers
// pin reset, software reset, ignored requests, mid-sequence pin reset and
// back-to-back software resets; a second instance (SYNC_STAGES=2,
// NUM_DOMAINS=1, RELEASE_GAP=1) covers the minimum configuration.
// Expected cause codes follow the RST_SEQ_CAUSE_EN build macro.
module tb_reset_seq_ctrl;

`ifdef RST_SEQ_CAUSE_EN
  localparam logic [1:0] CAUSE_PIN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
`else
  localparam logic [1:0] CAUSE_PIN = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       async_rst = 1'b0;
  logic       sw_req = 1'b0;
  logic [2:0] dom;
  logic       all_rel;
  logic       busy;
  logic [1:0] cause;
  logic [0:0] dom2;
  logic       all_rel2;
  logic       busy2;
  logic [1:0] cause2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reset_seq_ctrl dut (
    .clk_i         (clk),
    .async_rst_i   (async_rst),
    .sw_rst_req_i  (sw_req),
    .domain_rst_o  (dom),
    .all_released_o(all_rel),
    .busy_o        (busy),
    .rst_cause_o   (cause)
  );

  reset_seq_ctrl #(
    .SYNC_STAGES  (2),
    .NUM_DOMAINS  (1),
    .RELEASE_GAP  (1),
    .SW_RST_CYCLES(8)
  ) dut_min (
    .clk_i         (clk),
    .async_rst_i   (async_rst),
    .sw_rst_req_i  (1'b0),
    .domain_rst_o  (dom2),
    .all_released_o(all_rel2),
    .busy_o        (busy2),
    .rst_cause_o   (cause2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Number of domains released n edges into a sequence whose first release
  // is at edge 'first' and later ones every 'gap' edges.
  function automatic int released(input int n, input int first, input int gap, input int nd);
    int k;
    if (n < first) return 0;
    k = (n - first) / gap + 1;
    return (k > nd) ? nd : k;
  endfunction

  task automatic check_main(input string tag, input int n, input int first, input logic [1:0] exp_cause);
    int k;
    k = released(n, first, 4, 3);
    check({tag, "_dom"},   32'(dom),     (32'd1 << k) - 32'd1);
    check({tag, "_all"},   32'(all_rel), 32'(k == 3));
    check({tag, "_busy"},  32'(busy),    32'(k != 3));
    check({tag, "_cause"}, 32'(cause),   32'(exp_cause));
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_dom"},    32'(dom),     32'd0);
    check({tag, "_all"},    32'(all_rel), 32'd0);
    check({tag, "_busy"},   32'(busy),    32'd1);
    check({tag, "_cause"},  32'(cause),   32'(CAUSE_PIN));
    check({tag, "_dom2"},   32'(dom2),    32'd0);
    check({tag, "_busy2"},  32'(busy2),   32'd1);
  endtask

  // Full pin-reset sequence; optionally pulses a software request while
  // domain 0 is the only one released, which must be ignored.
  task automatic pin_seq(input string tag, input bit pulse_sw);
    async_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_in_reset({tag, "_held"});
    @(negedge clk) async_rst = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      check_main($sformatf("%s_e%0d", tag, n), n, 4, CAUSE_PIN);
      check($sformatf("%s_min_dom_e%0d", tag, n), 32'(dom2),     32'(n >= 3));
      check($sformatf("%s_min_all_e%0d", tag, n), 32'(all_rel2), 32'(n >= 3));
      check($sformatf("%s_min_bsy_e%0d", tag, n), 32'(busy2),    32'(n < 3));
      if (pulse_sw && n == 4) begin
        @(negedge clk) sw_req = 1'b1;
      end
      if (pulse_sw && n == 5) begin
        @(negedge clk) sw_req = 1'b0;
      end
    end
  endtask

  // Software reset from RUN; with hold set the request stays high and must
  // retrigger one edge after the FSM returns to RUN.
  task automatic sw_seq(input string tag, input bit hold);
    @(negedge clk) sw_req = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_E_dom"},   32'(dom),     32'd0);
    check({tag, "_E_all"},   32'(all_rel), 32'd0);
    check({tag, "_E_busy"},  32'(busy),    32'd1);
    check({tag, "_E_cause"}, 32'(cause),   32'(CAUSE_SW));
    if (!hold) begin
      @(negedge clk) sw_req = 1'b0;
    end
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1 check_main($sformatf("%s_e%0d", tag, n), n, 8, CAUSE_SW);
    end
    if (hold) begin
      @(posedge clk);
      #1;
      check({tag, "_retrig_dom"},  32'(dom),  32'd0);
      check({tag, "_retrig_busy"}, 32'(busy), 32'd1);
      @(negedge clk) sw_req = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      check({tag, "_again_dom"}, 32'(dom),     32'd7);
      check({tag, "_again_all"}, 32'(all_rel), 32'd1);
    end
  endtask

  initial begin
    // Power-on pin reset and release.
    pin_seq("pin", 1'b0);

    // Stable in RUN with no request.
    repeat (3) @(posedge clk);
    #1 check_main("run_idle", 20, 4, CAUSE_PIN);

    // Single-cycle software request.
    sw_seq("sw", 1'b0);

    // Request during RELEASE is ignored.
    pin_seq("ign", 1'b1);

    // Pin reset mid-cycle while in SW_HOLD: immediate, no clock edge needed.
    @(negedge clk) sw_req = 1'b1;
    @(posedge clk);
    @(negedge clk) sw_req = 1'b0;
    repeat (3) @(posedge clk);
    #3 async_rst = 1'b0;
    #1 check_in_reset("swhold_drop");
    pin_seq("after_drop", 1'b0);

    // Back-to-back software resets from a held request.
    sw_seq("b2b", 1'b1);

    // Pin reset mid-cycle from RUN clears released domains at once.
    @(posedge clk);
    #4 async_rst = 1'b0;
    #1 check_in_reset("run_drop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
